// File: rtl/spi_frame_seq.sv
// spi_frame_seq: receives 11-bit serial frames (start, 8 data LSB first,
// even parity, stop) qualified by a one-cycle bit strobe. Good frames are
// presented on a valid/ready output register; bad stop bits, parity failures,
// inter-bit timeouts and overruns raise sticky flags cleared by err_clr.
module spi_frame_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       bit_en,
    input  logic       ready,
    input  logic       err_clr,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic [5:0] frame_count
);

    // Timeout fires on the edge where the idle-cycle counter would reach TIMEOUT.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    // Index value of the last bit before the stop bit (bits counted 1..10).
    localparam logic [3:0] LAST_IDX_M1 = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t      r_state;
    logic [9:0]  r_shreg;
    logic [3:0]  r_bit_idx;
    logic [7:0]  r_timer;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_busy;
    logic        r_perr;
    logic        r_ferr;
    logic        r_ovr;
    logic [5:0]  r_count;

    // After ten right-shifts the shift register holds:
    // [7:0] payload, [8] parity bit, [9] stop bit.
    logic w_in_check;
    logic w_stop_ok;
    logic w_parity_ok;
    logic w_frame_good;
    logic w_can_load;
    logic w_load;
    logic w_consume;
    logic w_timeout;
    logic w_set_perr;
    logic w_set_ferr;
    logic w_set_ovr;

    assign w_in_check   = (r_state == ST_CHECK);
    assign w_stop_ok    = r_shreg[9];
    assign w_parity_ok  = ~(^r_shreg[8:0]);
    assign w_frame_good = w_in_check && w_stop_ok && w_parity_ok;

    // A slot is free when nothing is held or the held frame is leaving now.
    assign w_can_load   = !r_valid || ready;
    assign w_load       = w_frame_good && w_can_load;
    assign w_consume    = r_valid && ready;

    // A strobe in the same cycle always wins over the timeout.
    assign w_timeout    = (r_state == ST_RECV) && !bit_en && (r_timer == TIMEOUT_M1);

    // Outcome priority in CHECK: stop bit, then parity, then load/overrun.
    assign w_set_ferr   = (w_in_check && !w_stop_ok) || w_timeout;
    assign w_set_perr   = w_in_check && w_stop_ok && !w_parity_ok;
    assign w_set_ovr    = w_frame_good && !w_can_load;

    // Frame sequencer, output register, handshake and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_timer   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Only a low rx on a strobe is a start bit; high is line idle.
                    if (bit_en && !rx) begin
                        r_state   <= ST_RECV;
                        r_busy    <= 1'b1;
                        r_bit_idx <= '0;
                        r_timer   <= '0;
                        r_shreg   <= '0;
                    end
                end
                ST_RECV: begin
                    if (bit_en) begin
                        r_shreg <= {rx, r_shreg[9:1]};
                        r_timer <= '0;
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == LAST_IDX_M1) begin
                            r_state <= ST_CHECK;
                        end
                    end else if (w_timeout) begin
                        // Abandon the partial frame entirely.
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_bit_idx <= '0;
                        r_timer   <= '0;
                        r_shreg   <= '0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                ST_CHECK: begin
                    // Strobes here are deliberately ignored: the frame is judged
                    // this cycle and a start bit arriving now is lost.
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_bit_idx <= '0;
                    r_timer   <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_bit_idx <= '0;
                    r_timer   <= '0;
                end
            endcase

            // A load in the same cycle as a transfer keeps valid high with new data.
            if (w_load) begin
                r_data  <= r_shreg[7:0];
                r_valid <= 1'b1;
                r_count <= r_count + 6'd1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end

            // Clear first, then set, so a coincident new error survives err_clr.
            r_perr <= (r_perr && !err_clr) || w_set_perr;
            r_ferr <= (r_ferr && !err_clr) || w_set_ferr;
            r_ovr  <= (r_ovr  && !err_clr) || w_set_ovr;
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign busy        = r_busy;
    assign parity_err  = r_perr;
    assign frame_err   = r_ferr;
    assign overrun     = r_ovr;
    assign frame_count = r_count;

endmodule

// File: tb/tb_spi_frame_seq.sv
// Bench for spi_frame_seq: directed and randomized frames compared against a
// frame-level reference model (outcome computed from whole frames, valid/ready
// handshake tracked cycle by cycle).
module tb_spi_frame_seq;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       bit_en = 1'b0;
    logic       ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic [5:0] frame_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] m_data = 8'h00;
    bit         m_valid = 0;
    bit         m_busy = 0;
    bit         m_perr = 0;
    bit         m_ferr = 0;
    bit         m_ovr = 0;
    int         m_cnt = 0;

    // 0: ready held by test, 2: ready random every cycle
    int rdy_mode = 0;
    bit err_mode = 0;

    always #5 clk = ~clk;

    spi_frame_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .bit_en      (bit_en),
        .ready       (ready),
        .err_clr     (err_clr),
        .data        (data),
        .valid       (valid),
        .busy        (busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    function automatic logic [18:0] dut_snap();
        return {data, valid, busy, parity_err, frame_err, overrun, frame_count};
    endfunction

    function automatic logic [18:0] mdl_snap();
        return {m_data, m_valid, m_busy, m_perr, m_ferr, m_ovr, 6'(m_cnt)};
    endfunction

    // Arrival order: [0] start, [8:1] data LSB first, [9] parity, [10] stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = (^d) ^ bad_par;
        return {~bad_stop, p, d, 1'b0};
    endfunction

    // Advance one clock. check=1 marks the cycle right after the stop strobe,
    // where the whole frame is judged; tmo=1 marks an inter-bit timeout.
    task automatic step(input bit check, input logic [10:0] fr, input bit tmo);
        bit loaded;
        bit consume;
        bit s_p;
        bit s_f;
        bit s_o;
        loaded = 0; s_p = 0; s_f = tmo; s_o = 0;
        if (rdy_mode == 2) ready = ($urandom_range(0, 1) == 1);
        if (err_mode) err_clr = ($urandom_range(0, 7) == 0);
        consume = m_valid && ready;
        if (check) begin
            if (fr[10] == 1'b0) s_f = 1;
            else if ((^fr[9:1]) == 1'b1) s_p = 1;
            else if (!m_valid || ready) begin
                m_data = fr[8:1];
                m_valid = 1;
                m_cnt = (m_cnt + 1) % 64;
                loaded = 1;
            end else s_o = 1;
        end
        if (consume && !loaded) m_valid = 0;
        m_perr = (m_perr && !err_clr) || s_p;
        m_ferr = (m_ferr && !err_clr) || s_f;
        m_ovr  = (m_ovr  && !err_clr) || s_o;
        @(posedge clk);
        #1;
        if (check || tmo) m_busy = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bit_en = 0;
            rx = 1'($urandom);
            step(0, 11'h0, 0);
        end
    endtask

    // Strobe bits first..last, leaving gap-1 quiet cycles after each (none after the stop).
    task automatic send_bits(input logic [10:0] fr, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            bit_en = 1;
            rx = fr[i];
            step(0, fr, 0);
            if (i == 0) m_busy = 1;
            if (i < 10) begin
                for (int g = 1; g < gap; g++) begin
                    bit_en = 0;
                    rx = 1'($urandom);
                    step(0, fr, 0);
                end
            end
        end
        bit_en = 0;
    endtask

    task automatic check_cycle(input logic [10:0] fr, input bit strobe);
        bit_en = strobe;
        rx = 1'b0;
        step(1, fr, 0);
        bit_en = 0;
        rx = 1'b1;
        $display("frame data=%h par=%b stop=%b -> data=%h valid=%b cnt=%0d p%b f%b o%b",
                 fr[8:1], fr[9], fr[10], data, valid, frame_count, parity_err, frame_err, overrun);
    endtask

    task automatic send_frame(input logic [10:0] fr, input int gap);
        send_bits(fr, 0, 10, gap);
        check_cycle(fr, 0);
    endtask

    task automatic do_reset();
        rst = 1; bit_en = 1; rx = 0; ready = 1; err_clr = 1;
        @(posedge clk);
        #1;
        rst = 0; bit_en = 0; rx = 1; err_clr = 0;
        m_data = 8'h00; m_valid = 0; m_busy = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (dut_snap() !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", dut_snap(), 19'h0);
        end
        // Strobe with rx=1 in IDLE must be ignored.
        ready = 0;
        bit_en = 1; rx = 1;
        step(0, 11'h0, 0);
        bit_en = 0;
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_rx_high: busy got %b want 0", busy);
        end
    endtask

    task automatic test_good_frame();
        logic [10:0] fr;
        rdy_mode = 0; ready = 1;
        fr = 11'b10_1010_0101_0;
        send_bits(fr, 0, 4, 4);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL a5_busy_mid: got %b want 1", busy);
        end
        send_bits(fr, 5, 10, 4);
        n_vec++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL a5_latency: valid got %b want 0 one edge after stop", valid);
        end
        check_cycle(fr, 0);
        n_vec++;
        if ({data, valid, frame_count} !== {8'hA5, 1'b1, 6'd1}) begin
            n_bad++;
            $display("FAIL a5_load: got data=%h valid=%b cnt=%0d want A5 1 1", data, valid, frame_count);
        end
        n_vec++;
        if (dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL a5_state: got %h want %h", dut_snap(), mdl_snap());
        end
        idle(1);
        n_vec++;
        if (valid !== 1'b0 || data !== 8'hA5) begin
            n_bad++;
            $display("FAIL a5_consume: got valid=%b data=%h want 0 A5", valid, data);
        end
    endtask

    task automatic test_parity();
        logic [10:0] fr;
        ready = 1;
        fr = mk_frame(8'hA5, 1, 0);
        send_frame(fr, 4);
        n_vec++;
        if ({parity_err, valid, frame_count} !== {1'b1, 1'b0, 6'd1} || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL parity_set: got %h want %h", dut_snap(), mdl_snap());
        end
        err_clr = 1;
        step(0, 11'h0, 0);
        err_clr = 0;
        n_vec++;
        if (parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_clear: got %b want 0", parity_err);
        end
        // err_clr coinciding with a new parity error: flag must end set.
        send_bits(fr, 0, 10, 2);
        err_clr = 1;
        check_cycle(fr, 0);
        err_clr = 0;
        n_vec++;
        if (parity_err !== 1'b1 || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL parity_set_wins: got %h want %h", dut_snap(), mdl_snap());
        end
        err_clr = 1;
        step(0, 11'h0, 0);
        err_clr = 0;
    endtask

    task automatic test_overrun();
        ready = 0;
        send_frame(mk_frame(8'h3C, 0, 0), 3);
        idle(2);
        send_frame(mk_frame(8'h81, 0, 0), 3);
        n_vec++;
        if ({data, valid, overrun, frame_count} !== {8'h3C, 1'b1, 1'b1, 6'd2} || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL overrun: got %h want %h", dut_snap(), mdl_snap());
        end
        ready = 1;
        step(0, 11'h0, 0);
        ready = 0;
        n_vec++;
        if (valid !== 1'b0 || data !== 8'h3C) begin
            n_bad++;
            $display("FAIL overrun_drain: got valid=%b data=%h want 0 3C", valid, data);
        end
        err_clr = 1;
        step(0, 11'h0, 0);
        err_clr = 0;
    endtask

    task automatic test_timeout();
        logic [10:0] fr;
        ready = 1;
        fr = mk_frame(8'h77, 0, 0);
        send_bits(fr, 0, 3, 1);
        idle(TIMEOUT - 1);
        n_vec++;
        if (busy !== 1'b1 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got busy=%b ferr=%b want 1 0", busy, frame_err);
        end
        bit_en = 0;
        step(0, fr, 1);
        n_vec++;
        if ({busy, frame_err} !== 2'b01 || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL timeout_fire: got %h want %h", dut_snap(), mdl_snap());
        end
        idle(3);
        send_frame(mk_frame(8'h12, 0, 0), 4);
        n_vec++;
        if ({data, valid} !== {8'h12, 1'b1} || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL timeout_recover: got %h want %h", dut_snap(), mdl_snap());
        end
        err_clr = 1;
        step(0, 11'h0, 0);
        err_clr = 0;
    endtask

    task automatic test_back_to_back();
        ready = 1;
        // Start strobe during CHECK is lost.
        send_bits(mk_frame(8'h5A, 0, 0), 0, 10, 1);
        check_cycle(mk_frame(8'h5A, 0, 0), 1);
        idle(1);
        n_vec++;
        if (busy !== 1'b0 || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL check_strobe_lost: got %h want %h", dut_snap(), mdl_snap());
        end
        // Next frame starting the cycle after CHECK, with a stop-bit error between.
        send_frame(mk_frame(8'hE1, 0, 1), 1);
        send_frame(mk_frame(8'h96, 0, 0), 1);
        n_vec++;
        if ({data, frame_err} !== {8'h96, 1'b1} || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL back_to_back: got %h want %h", dut_snap(), mdl_snap());
        end
        err_clr = 1;
        step(0, 11'h0, 0);
        err_clr = 0;
    endtask

    task automatic test_random();
        logic [10:0] fr;
        rdy_mode = 2;
        err_mode = 1;
        for (int f = 0; f < 40; f++) begin
            fr = mk_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            send_frame(fr, $urandom_range(1, 5));
            n_vec++;
            if (dut_snap() !== mdl_snap()) begin
                n_bad++;
                $display("FAIL random_frame%0d: got %h want %h", f, dut_snap(), mdl_snap());
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                bit_en = ($urandom_range(0, 1) == 1);
                rx = 1'b1;
                step(0, 11'h0, 0);
            end
            bit_en = 0;
            n_vec++;
            if (dut_snap() !== mdl_snap()) begin
                n_bad++;
                $display("FAIL random_idle%0d: got %h want %h", f, dut_snap(), mdl_snap());
            end
        end
        rdy_mode = 0;
        err_mode = 0;
        err_clr = 0;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        ready = 1;
        for (int f = 0; f < 64; f++) begin
            send_frame(mk_frame(8'(f * 7 + 1), 0, 0), 1);
            if (f == 62) begin
                n_vec++;
                if (frame_count !== 6'd63) begin
                    n_bad++;
                    $display("FAIL count_63: got %0d want 63", frame_count);
                end
            end
        end
        n_vec++;
        if (frame_count !== 6'd0 || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL count_wrap: got %h want %h", dut_snap(), mdl_snap());
        end
        // Leave flags and a held frame set so reset has something to clear.
        send_frame(mk_frame(8'h44, 1, 0), 1);
        ready = 0;
        send_frame(mk_frame(8'hC3, 0, 0), 1);
        send_bits(mk_frame(8'hF0, 0, 0), 0, 5, 2);
        n_vec++;
        if ({busy, valid, parity_err} !== 3'b111) begin
            n_bad++;
            $display("FAIL pre_reset: got busy=%b valid=%b perr=%b want 1 1 1", busy, valid, parity_err);
        end
        do_reset();
        n_vec++;
        if (dut_snap() !== 19'h0) begin
            n_bad++;
            $display("FAIL midframe_reset: got %h want %h", dut_snap(), 19'h0);
        end
        ready = 1;
        send_frame(mk_frame(8'h5E, 0, 0), 2);
        n_vec++;
        if ({data, valid, frame_count} !== {8'h5E, 1'b1, 6'd1} || dut_snap() !== mdl_snap()) begin
            n_bad++;
            $display("FAIL post_reset_frame: got %h want %h", dut_snap(), mdl_snap());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity();
        test_overrun();
        test_timeout();
        test_back_to_back();
        test_random();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
